// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-stream frame FIFO.
// Contents:
//   wr_state_e - write-side FSM encoding (WRITE accepts a frame, DROP discards the rest of one)
//   ptr_width  - pointer width for a given address width; the extra MSB tells full from empty
package axis_pkg;

    typedef enum logic {
        WRITE = 1'b0,
        DROP  = 1'b1
    } wr_state_e;

    function automatic int unsigned ptr_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port RAM with a registered read port.
// Ports:
//   clk        - clock
//   wr_en_i    - write strobe; wr_addr_i / wr_data_i give the location and word
//   rd_en_i    - read strobe; rd_data_o takes mem[rd_addr_i] on the next edge and holds otherwise
module axis_fifo_ram #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned WIDTH      = 10
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [WIDTH-1:0]      rd_data_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Storage array and read register; no reset so the array maps onto a RAM macro.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axis_frame_fifo.sv
// Store-and-forward AXI-stream frame FIFO. Frames become visible to the sink only
// once their tlast word is written; frames that do not fit are dropped whole.
// The input never back-pressures.
// Ports:
//   clk, rst              - clock, asynchronous active-low reset
//   input_axis_*          - write-side stream (tready is 1 from the first edge after reset)
//   output_axis_*         - read-side stream, registered, AXI hold-until-accepted
//   overflow              - one-cycle pulse: frame dropped for lack of space
//   bad_frame             - one-cycle pulse: frame dropped because tuser was set on tlast
//   good_frame            - one-cycle pulse: frame committed
// Build option:
//   AXIS_FIFO_DROP_BAD_FRAME_EN - discard frames ending with tuser=1 and force output tuser to 0;
//                                 when undefined tuser is forwarded and bad_frame stays 0.
module axis_frame_fifo
    import axis_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] input_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] input_axis_tkeep,
    input  logic                  input_axis_tvalid,
    output logic                  input_axis_tready,
    input  logic                  input_axis_tlast,
    input  logic                  input_axis_tuser,
    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic [KEEP_WIDTH-1:0] output_axis_tkeep,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    output logic                  output_axis_tlast,
    output logic                  output_axis_tuser,
    output logic                  overflow,
    output logic                  bad_frame,
    output logic                  good_frame
);

    localparam int unsigned PTR_W   = ptr_width(ADDR_WIDTH);
    localparam int unsigned ENTRY_W = DATA_WIDTH + KEEP_WIDTH + 2;

    wr_state_e          state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_cur_q, wr_ptr_cur_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               tready_q;
    logic               overflow_q, overflow_d;
    logic               good_q, good_d;
    logic               bad_q, bad_d;
    logic               mem_vld_q;
    logic               out_vld_q;
    logic [ENTRY_W-1:0] out_word_q;

    logic               full_c, empty_c, beat_c, bad_user_c;
    logic               wr_en_c, rd_en_c, adv_c;
    logic [ENTRY_W-1:0] wr_word_c, ram_rd_data, load_word_c;

    // Full compares against the speculative write point, empty against the commit point.
    assign full_c  = (wr_ptr_cur_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                     (wr_ptr_cur_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign beat_c  = input_axis_tvalid && tready_q;
    assign wr_word_c = {input_axis_tlast, input_axis_tuser, input_axis_tkeep, input_axis_tdata};

`ifdef AXIS_FIFO_DROP_BAD_FRAME_EN
    assign bad_user_c = input_axis_tuser;
`else
    assign bad_user_c = 1'b0;
`endif

    // Write FSM: next state, pointer updates and status pulses.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        wr_ptr_cur_d = wr_ptr_cur_q;
        wr_en_c      = 1'b0;
        overflow_d   = 1'b0;
        good_d       = 1'b0;
        bad_d        = 1'b0;
        unique case (state_q)
            WRITE: begin
                if (beat_c) begin
                    if (full_c) begin
                        // Rewind to the last commit; the partial frame is abandoned.
                        wr_ptr_cur_d = wr_ptr_q;
                        if (input_axis_tlast) begin
                            overflow_d = 1'b1;
                        end else begin
                            state_d = DROP;
                        end
                    end else begin
                        wr_en_c      = 1'b1;
                        wr_ptr_cur_d = wr_ptr_cur_q + PTR_W'(1);
                        if (input_axis_tlast) begin
                            if (bad_user_c) begin
                                wr_ptr_cur_d = wr_ptr_q;
                                bad_d        = 1'b1;
                            end else begin
                                wr_ptr_d = wr_ptr_cur_q + PTR_W'(1);
                                good_d   = 1'b1;
                            end
                        end
                    end
                end
            end
            DROP: begin
                if (beat_c && input_axis_tlast) begin
                    overflow_d = 1'b1;
                    state_d    = WRITE;
                end
            end
            default: state_d = WRITE;
        endcase
    end

    // Read side: RAM read register and output register advance together whenever
    // the output register is free or being accepted.
    always_comb begin
        adv_c    = output_axis_tready || !out_vld_q;
        rd_en_c  = adv_c && !empty_c;
        rd_ptr_d = rd_ptr_q;
        if (rd_en_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        load_word_c = ram_rd_data;
`ifdef AXIS_FIFO_DROP_BAD_FRAME_EN
        load_word_c[ENTRY_W-2] = 1'b0;
`endif
    end

    // State, pointers, status pulses and output pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= WRITE;
            wr_ptr_q     <= '0;
            wr_ptr_cur_q <= '0;
            rd_ptr_q     <= '0;
            tready_q     <= 1'b0;
            overflow_q   <= 1'b0;
            good_q       <= 1'b0;
            bad_q        <= 1'b0;
            mem_vld_q    <= 1'b0;
            out_vld_q    <= 1'b0;
            out_word_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            wr_ptr_cur_q <= wr_ptr_cur_d;
            rd_ptr_q     <= rd_ptr_d;
            tready_q     <= 1'b1;
            overflow_q   <= overflow_d;
            good_q       <= good_d;
            bad_q        <= bad_d;
            if (adv_c) begin
                mem_vld_q <= !empty_c;
                out_vld_q <= mem_vld_q;
                if (mem_vld_q) begin
                    out_word_q <= load_word_c;
                end
            end
        end
    end

    axis_fifo_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WIDTH      (ENTRY_W)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_en_c),
        .wr_addr_i (wr_ptr_cur_q[ADDR_WIDTH-1:0]),
        .wr_data_i (wr_word_c),
        .rd_en_i   (rd_en_c),
        .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data_o (ram_rd_data)
    );

    assign input_axis_tready  = tready_q;
    assign output_axis_tvalid = out_vld_q;
    assign output_axis_tlast  = out_word_q[ENTRY_W-1];
    assign output_axis_tuser  = out_word_q[ENTRY_W-2];
    assign output_axis_tkeep  = out_word_q[DATA_WIDTH +: KEEP_WIDTH];
    assign output_axis_tdata  = out_word_q[DATA_WIDTH-1:0];
    assign overflow           = overflow_q;
    assign good_frame         = good_q;
    assign bad_frame          = bad_q;

endmodule

// File: tb/tb_axis_frame_fifo.sv
// Scoreboard bench for axis_frame_fifo with a 16-deep FIFO.
module tb_axis_frame_fifo;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned KW    = 1;
    localparam int unsigned EW    = DW + KW + 2;
    localparam int unsigned DEPTH = 16;

`ifdef AXIS_FIFO_DROP_BAD_FRAME_EN
    localparam bit DROP_BAD = 1'b1;
`else
    localparam bit DROP_BAD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [KW-1:0] in_keep = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_last = 1'b0;
    logic          in_user = 1'b0;
    logic [DW-1:0] out_data;
    logic [KW-1:0] out_keep;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic          out_user;
    logic          ovf;
    logic          badf;
    logic          goodf;

    logic [EW-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int n_good = 0, n_ovf = 0, n_badf = 0, n_out = 0;
    int sink_mode = 0;

    always #5 clk = ~clk;

    axis_frame_fifo #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .KEEP_WIDTH (KW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .input_axis_tdata   (in_data),
        .input_axis_tkeep   (in_keep),
        .input_axis_tvalid  (in_valid),
        .input_axis_tready  (in_ready),
        .input_axis_tlast   (in_last),
        .input_axis_tuser   (in_user),
        .output_axis_tdata  (out_data),
        .output_axis_tkeep  (out_keep),
        .output_axis_tvalid (out_valid),
        .output_axis_tready (out_ready),
        .output_axis_tlast  (out_last),
        .output_axis_tuser  (out_user),
        .overflow           (ovf),
        .bad_frame          (badf),
        .good_frame         (goodf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Sink: 0 = always ready, 1 = stalled, 2 = random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (sink_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake, checks hold while stalled, counts pulses.
    initial begin
        logic [EW-1:0] w, prev_w, e;
        bit prev_stall;
        prev_stall = 1'b0;
        prev_w     = '0;
        forever begin
            @(negedge clk);
            w = {out_last, out_user, out_keep, out_data};
            if (!rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) check("hold_while_stalled", 32'({out_valid, w}), 32'({1'b1, prev_w}));
                if (out_valid && out_ready) begin
                    n_out++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_output actual=0x%0h required=none", w);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_word", 32'(w), 32'(e));
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_w     = w;
                if (goodf) n_good++;
                if (ovf)   n_ovf++;
                if (badf)  n_badf++;
            end
        end
    end

    // One beat; called and returns at posedge+1.
    task automatic drive_beat(input logic [DW-1:0] d, input bit last, input bit user);
        in_data  = d;
        in_keep  = '1;
        in_last  = last;
        in_user  = user;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_user  = 1'b0;
    endtask

    task automatic send_frame(input int len, input int base, input bit last_user,
                              input bit rand_user, input bit keep_ok);
        for (int i = 0; i < len; i++) begin
            logic [DW-1:0] d;
            bit last, user;
            d    = DW'(base + i);
            last = (i == len - 1);
            user = last ? last_user : (rand_user ? 1'($urandom_range(0, 1)) : 1'b0);
            if (keep_ok) exp_q.push_back({last, DROP_BAD ? 1'b0 : user, 1'b1, d});
            drive_beat(d, last, user);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(posedge clk);
            c++;
        end
        #1;
        check(name, 32'(exp_q.size()), 32'd0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int g0, o0, b0, c0, n_long, len, c;
        bit ok;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_pulses", 32'({ovf, badf, goodf}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", 32'(in_ready), 32'd1);
        sink_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        // Single 4-word frame with commit-to-output latency
        g0 = n_good;
        send_frame(4, 1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("lat_edge_n_valid", 32'(out_valid), 32'd0);
        check("good_pulse", 32'(goodf), 32'd1);
        @(negedge clk);
        check("lat_edge_n1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_edge_n2_word", 32'({out_valid, out_data}), 32'h101);
        @(posedge clk);
        #1;
        wait_drain("drain_t1", 100);
        check("t1_good_count", 32'(n_good - g0), 32'd1);

        // Full-depth frame fits, following 1-word frame overflows
        sink_mode = 1;
        @(posedge clk);
        #1;
        g0 = n_good; o0 = n_ovf; c0 = n_out;
        send_frame(16, 'h20, 1'b0, 1'b0, 1'b1);
        send_frame(1, 'h40, 1'b0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("t2_ovf_count", 32'(n_ovf - o0), 32'd1);
        check("t2_good_count", 32'(n_good - g0), 32'd1);
        check("t2_stalled_head", 32'({out_valid, out_data}), 32'h120);
        sink_mode = 0;
        wait_drain("drain_t2", 200);
        check("t2_out_count", 32'(n_out - c0), 32'd16);

        // 20-word frame into 16-deep FIFO drops, next frame passes
        o0 = n_ovf; c0 = n_out;
        send_frame(20, 'h50, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("t3_ovf_pulse_beat20", 32'(ovf), 32'd1);
        @(posedge clk);
        #1;
        send_frame(3, 'h60, 1'b0, 1'b0, 1'b1);
        wait_drain("drain_t3", 100);
        check("t3_ovf_count", 32'(n_ovf - o0), 32'd1);
        check("t3_out_count", 32'(n_out - c0), 32'd3);

        // tuser on the last beat
        g0 = n_good; b0 = n_badf;
        send_frame(3, 'h70, 1'b1, 1'b0, !DROP_BAD);
        @(negedge clk);
        check("t4_bad_pulse", 32'(badf), 32'(DROP_BAD));
        check("t4_good_pulse", 32'(goodf), 32'(!DROP_BAD));
        @(posedge clk);
        #1;
        wait_drain("drain_t4", 100);
        check("t4_bad_count", 32'(n_badf - b0), 32'(DROP_BAD));

        // Random sink, 200 frames, oversize frames always drop
        sink_mode = 2;
        o0 = n_ovf;
        n_long = 0;
        for (int f = 0; f < 200; f++) begin
            if ($urandom_range(0, 9) == 0) len = int'($urandom_range(17, 19));
            else len = int'($urandom_range(1, 12));
            ok = (len <= DEPTH);
            if (ok) begin
                c = 0;
                while (exp_q.size() + len > DEPTH && c < 2000) begin
                    @(posedge clk);
                    c++;
                end
                #1;
                if (c >= 2000) begin
                    check("t5_space_wait_timeout", 32'(exp_q.size()), 32'(DEPTH - len));
                end
            end else begin
                n_long++;
            end
            send_frame(len, f * 7, 1'b0, 1'b1, ok);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        sink_mode = 0;
        wait_drain("drain_t5", 2000);
        check("t5_ovf_count", 32'(n_ovf - o0), 32'(n_long));

        // Reset mid-frame with two committed frames buffered
        sink_mode = 1;
        @(posedge clk);
        #1;
        send_frame(3, 'h80, 1'b0, 1'b0, 1'b1);
        send_frame(3, 'h90, 1'b0, 1'b0, 1'b1);
        drive_beat(8'hA0, 1'b0, 1'b0);
        drive_beat(8'hA1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("t6_pre_rst_head", 32'({out_valid, out_data}), 32'h180);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("t6_valid_drops", 32'(out_valid), 32'd0);
        check("t6_ready_in_rst", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        sink_mode = 0;
        repeat (6) @(posedge clk);
        #1;
        check("t6_empty_after_rst", 32'(out_valid), 32'd0);
        c0 = n_out;
        send_frame(4, 'hB0, 1'b0, 1'b0, 1'b1);
        wait_drain("drain_t6", 100);
        check("t6_out_count", 32'(n_out - c0), 32'd4);
        if (!DROP_BAD) check("bad_frame_never", 32'(n_badf), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
